// File: rtl/trap_controller_pkg.sv
// trap_controller_pkg: shared interrupt codes, trap FSM states and the
// interrupt cause encoding used by the trap controller.
package trap_controller_pkg;

   localparam logic [4:0] IRQ_MSI = 5'd3;
   localparam logic [4:0] IRQ_MTI = 5'd7;
   localparam logic [4:0] IRQ_MEI = 5'd11;

   typedef enum logic [1:0] {
      TRAP_IDLE     = 2'd0,
      TRAP_COMMIT   = 2'd1,
      TRAP_REDIRECT = 2'd2,
      TRAP_WFI      = 2'd3
   } trap_state_e;

   // Interrupt causes carry the MSB flag with the code zero-extended below it.
   function automatic logic [31:0] interrupt_cause(input logic [4:0] code);
      return {1'b1, 26'b0, code};
   endfunction

endpackage

// File: rtl/trap_controller_irq_priority_encoder.sv
// irq_priority_encoder: picks the highest-priority pending machine interrupt
// (MEI > MSI > MTI) and reports whether one may be taken.
module irq_priority_encoder
   import trap_controller_pkg::*;
(
   input  logic [31:0] i_pending,
   input  logic        i_irq_en,
   output logic        o_valid,
   output logic [4:0]  o_code
);

   always_comb begin
      o_valid = i_irq_en & (|i_pending);
      o_code  = i_pending[IRQ_MEI] ? IRQ_MEI :
                i_pending[IRQ_MSI] ? IRQ_MSI :
                i_pending[IRQ_MTI] ? IRQ_MTI : 5'd0;
   end

endmodule

// File: rtl/trap_controller.sv
// trap_controller: sequences exceptions and interrupts into the CSR handler
// with a registered commit pulse, redirect handshake and WFI stall/wake.
module trap_controller
   import trap_controller_pkg::*;
#(
   parameter logic [31:0] IRQ_IMPL   = 32'h0000_0888,
   parameter bit          WFI_ENABLE = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        exc_valid,
   input  logic [31:0] exc_cause,
   input  logic [31:0] exc_tval,
   input  logic [31:0] pc,
   input  logic        boundary,
   input  logic        wfi_event,
   input  logic        mstatus_mie,
   input  logic [1:0]  privilege_mode,
   input  logic [31:0] mie,
   input  logic [31:0] mip,
   input  logic        exception_select,
   output logic        exception_event,
   output logic [31:0] cause,
   output logic [31:0] trap_pc,
   output logic [31:0] badaddr,
   output logic        trap_busy,
   output logic        trap_ack,
   output logic        wfi_stall,
   output logic [31:0] trap_count
);

   trap_state_e r_state, w_next;
   logic        r_trap_ack;
   logic [31:0] r_cause, r_trap_pc, r_badaddr, r_trap_count;
   logic [31:0] w_pending;
   logic        w_irq_en, w_irq_valid, w_take_exc, w_take_irq;
   logic [4:0]  w_irq_code;

   assign w_pending = mip & mie & IRQ_IMPL;
   assign w_irq_en  = mstatus_mie | (privilege_mode != 2'b11);

   irq_priority_encoder u_prio (
      .i_pending (w_pending),
      .i_irq_en  (w_irq_en),
      .o_valid   (w_irq_valid),
      .o_code    (w_irq_code)
   );

   // The ack cycle is not a boundary: the FSM is still dropping exc_valid
   // and loading the handler PC, so nothing new is taken until it clears.
   always_comb begin
      w_next     = r_state;
      w_take_exc = 1'b0;
      w_take_irq = 1'b0;
      unique case (r_state)
         TRAP_IDLE: begin
            if (!r_trap_ack) begin
               if (exc_valid) begin
                  w_take_exc = 1'b1;
                  w_next     = TRAP_COMMIT;
               end else if (boundary && w_irq_valid) begin
                  w_take_irq = 1'b1;
                  w_next     = TRAP_COMMIT;
               end else if (wfi_event && WFI_ENABLE) begin
                  w_next = TRAP_WFI;
               end
            end
         end
         TRAP_COMMIT:   w_next = TRAP_REDIRECT;
         TRAP_REDIRECT: w_next = exception_select ? TRAP_IDLE : TRAP_REDIRECT;
         TRAP_WFI:      w_next = (|w_pending) ? TRAP_IDLE : TRAP_WFI;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= TRAP_IDLE;
         r_trap_ack   <= 1'b0;
         r_cause      <= '0;
         r_trap_pc    <= '0;
         r_badaddr    <= '0;
         r_trap_count <= '0;
      end else begin
         r_state    <= w_next;
         r_trap_ack <= (r_state == TRAP_REDIRECT) && exception_select;
         if (w_take_exc) begin
            r_cause   <= exc_cause;
            r_trap_pc <= pc;
            r_badaddr <= (exc_tval == 32'hFFFF_FFFF) ? pc : exc_tval;
         end else if (w_take_irq) begin
            r_cause   <= interrupt_cause(w_irq_code);
            r_trap_pc <= pc;
            r_badaddr <= '0;
         end
         if (r_state == TRAP_COMMIT) r_trap_count <= r_trap_count + 32'd1;
      end
   end

   assign exception_event = (r_state == TRAP_COMMIT);
   assign trap_busy       = (r_state == TRAP_COMMIT) || (r_state == TRAP_REDIRECT);
   assign wfi_stall       = (r_state == TRAP_WFI);
   assign trap_ack        = r_trap_ack;
   assign cause           = r_cause;
   assign trap_pc         = r_trap_pc;
   assign badaddr         = r_badaddr;
   assign trap_count      = r_trap_count;

endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed-vector bench for trap_controller covering
// exceptions, interrupt priority/masking, collisions, WFI and async reset.
module tb_trap_controller;

   logic        clk = 1'b0;
   logic        resetn, exc_valid, boundary, wfi_event, mstatus_mie, exception_select;
   logic [31:0] exc_cause, exc_tval, pc, mie, mip;
   logic [1:0]  privilege_mode;
   logic        exception_event, trap_busy, trap_ack, wfi_stall;
   logic [31:0] cause, trap_pc, badaddr, trap_count;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   trap_controller dut (
      .clk(clk), .resetn(resetn), .exc_valid(exc_valid), .exc_cause(exc_cause),
      .exc_tval(exc_tval), .pc(pc), .boundary(boundary), .wfi_event(wfi_event),
      .mstatus_mie(mstatus_mie), .privilege_mode(privilege_mode), .mie(mie), .mip(mip),
      .exception_select(exception_select), .exception_event(exception_event),
      .cause(cause), .trap_pc(trap_pc), .badaddr(badaddr), .trap_busy(trap_busy),
      .trap_ack(trap_ack), .wfi_stall(wfi_stall), .trap_count(trap_count)
   );

   // Waits up to budget negedges for exception_event; returns at the COMMIT negedge.
   task automatic wait_event(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = exception_event;
      end
   endtask

   // From the COMMIT negedge: drive the redirect and return at the ack negedge.
   task automatic finish_trap(output bit acked);
      @(negedge clk);
      exception_select = 1'b1;
      @(negedge clk);
      acked            = trap_ack;
      exception_select = 1'b0;
      exc_valid        = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0; exc_valid = 0; exc_cause = 0; exc_tval = 0; pc = 0; boundary = 0;
      wfi_event = 0; mstatus_mie = 0; privilege_mode = 2'b11; mie = 0; mip = 0;
      exception_select = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({exception_event, trap_busy, trap_ack, wfi_stall} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got %b want 0000", {exception_event, trap_busy, trap_ack, wfi_stall});
      end
      checks++;
      if ({cause, trap_pc, badaddr, trap_count} !== 128'd0) begin
         errors++; $display("FAIL reset_regs got %h %h %h %h want zeros", cause, trap_pc, badaddr, trap_count);
      end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_illegal;
      bit seen, acked;
      exc_valid = 1; exc_cause = 32'd2; pc = 32'h8000_0010; exc_tval = 32'h0000_0013;
      wait_event(1, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL illegal_latency got event=0 want 1"); end
      checks++;
      if ({cause, badaddr, trap_pc} !== {32'd2, 32'h13, 32'h8000_0010}) begin
         errors++; $display("FAIL illegal_fields got %h %h %h want 2 13 80000010", cause, badaddr, trap_pc);
      end
      checks++;
      if (trap_busy !== 1'b1) begin errors++; $display("FAIL illegal_busy got %b want 1", trap_busy); end
      @(negedge clk);
      exception_select = 1;
      checks++;
      if ({exception_event, trap_busy, trap_count} !== {1'b0, 1'b1, 32'd1}) begin
         errors++; $display("FAIL illegal_redirect got ev=%b busy=%b cnt=%0d want 0 1 1", exception_event, trap_busy, trap_count);
      end
      @(negedge clk);
      acked = trap_ack;
      exception_select = 0; exc_valid = 0;
      checks++;
      if (acked !== 1'b1 || trap_busy !== 1'b0) begin
         errors++; $display("FAIL illegal_ack got ack=%b busy=%b want 1 0", acked, trap_busy);
      end
      @(negedge clk);
      checks++;
      if (trap_ack !== 1'b0 || cause !== 32'd2) begin
         errors++; $display("FAIL illegal_ack_pulse got ack=%b cause=%h want 0 2", trap_ack, cause);
      end
   endtask

   task automatic test_tval_pc;
      bit seen, acked;
      exc_valid = 1; exc_cause = 32'd1; pc = 32'h0000_0100; exc_tval = 32'hFFFF_FFFF;
      wait_event(1, seen);
      checks++;
      if (!seen || badaddr !== 32'h100 || cause !== 32'd1) begin
         errors++; $display("FAIL tval_pc got seen=%b badaddr=%h cause=%h want 1 100 1", seen, badaddr, cause);
      end
      finish_trap(acked);
      checks++;
      if (!acked || trap_count !== 32'd2) begin
         errors++; $display("FAIL tval_ack got ack=%b cnt=%0d want 1 2", acked, trap_count);
      end
   endtask

   task automatic test_priority;
      bit seen, acked;
      mie = 32'h888; mip = 32'h888; mstatus_mie = 1; boundary = 1; pc = 32'h8000_0200;
      wait_event(3, seen);
      checks++;
      if (!seen || cause !== 32'h8000_000B || badaddr !== 32'd0 || trap_pc !== 32'h8000_0200) begin
         errors++; $display("FAIL prio_mei got seen=%b cause=%h bad=%h pc=%h want 1 8000000b 0 80000200", seen, cause, badaddr, trap_pc);
      end
      finish_trap(acked);
      mip = 32'h088;
      wait_event(4, seen);
      checks++;
      if (!seen || cause !== 32'h8000_0003) begin
         errors++; $display("FAIL prio_msi got seen=%b cause=%h want 1 80000003", seen, cause);
      end
      finish_trap(acked);
      mip = 32'h080;
      wait_event(4, seen);
      checks++;
      if (!seen || cause !== 32'h8000_0007) begin
         errors++; $display("FAIL prio_mti got seen=%b cause=%h want 1 80000007", seen, cause);
      end
      finish_trap(acked);
      mip = 0;
      checks++;
      if (!acked || trap_count !== 32'd5) begin
         errors++; $display("FAIL prio_count got ack=%b cnt=%0d want 1 5", acked, trap_count);
      end
   endtask

   task automatic test_masked;
      bit seen, acked;
      @(negedge clk);
      mstatus_mie = 0; privilege_mode = 2'b11; mie = 32'h80; mip = 32'h80; boundary = 1;
      wait_event(100, seen);
      checks++;
      if (seen) begin errors++; $display("FAIL masked_quiet got event=1 want 0"); end
      privilege_mode = 2'b00;
      wait_event(3, seen);
      checks++;
      if (!seen || cause !== 32'h8000_0007) begin
         errors++; $display("FAIL masked_umode got seen=%b cause=%h want 1 80000007", seen, cause);
      end
      finish_trap(acked);
      mip = 0; privilege_mode = 2'b11;
      checks++;
      if (trap_count !== 32'd6) begin errors++; $display("FAIL masked_count got %0d want 6", trap_count); end
   endtask

   task automatic test_collision;
      bit seen, acked;
      @(negedge clk);
      mstatus_mie = 1; mie = 32'h80; mip = 32'h80; boundary = 1;
      exc_valid = 1; exc_cause = 32'd8; exc_tval = 32'd0; pc = 32'h8000_0300;
      wait_event(1, seen);
      checks++;
      if (!seen || cause !== 32'd8) begin
         errors++; $display("FAIL collide_exc got seen=%b cause=%h want 1 8", seen, cause);
      end
      finish_trap(acked);
      checks++;
      if (!acked || cause !== 32'd8) begin
         errors++; $display("FAIL collide_hold got ack=%b cause=%h want 1 8", acked, cause);
      end
      wait_event(4, seen);
      checks++;
      if (!seen || cause !== 32'h8000_0007) begin
         errors++; $display("FAIL collide_irq got seen=%b cause=%h want 1 80000007", seen, cause);
      end
      finish_trap(acked);
      mip = 0;
      checks++;
      if (trap_count !== 32'd8) begin errors++; $display("FAIL collide_count got %0d want 8", trap_count); end
   endtask

   task automatic test_wfi;
      bit seen, acked;
      @(negedge clk);
      mip = 0; mie = 32'h8; mstatus_mie = 0; boundary = 0; wfi_event = 1;
      @(negedge clk);
      wfi_event = 0;
      repeat (5) @(negedge clk);
      checks++;
      if (wfi_stall !== 1'b1) begin errors++; $display("FAIL wfi_stall got %b want 1", wfi_stall); end
      mip = 32'h8;
      @(negedge clk);
      checks++;
      if (wfi_stall !== 1'b0 || exception_event !== 1'b0) begin
         errors++; $display("FAIL wfi_wake got stall=%b ev=%b want 0 0", wfi_stall, exception_event);
      end
      boundary = 1;
      wait_event(10, seen);
      checks++;
      if (seen) begin errors++; $display("FAIL wfi_masked got event=1 want 0"); end
      mstatus_mie = 1;
      wait_event(3, seen);
      checks++;
      if (!seen || cause !== 32'h8000_0003) begin
         errors++; $display("FAIL wfi_irq got seen=%b cause=%h want 1 80000003", seen, cause);
      end
      finish_trap(acked);
      mip = 0;
      checks++;
      if (trap_count !== 32'd9) begin errors++; $display("FAIL wfi_count got %0d want 9", trap_count); end
   endtask

   task automatic test_async_reset;
      bit seen;
      @(negedge clk);
      exc_valid = 1; exc_cause = 32'd5; exc_tval = 32'h44; pc = 32'h8000_0400;
      wait_event(1, seen);
      @(negedge clk);
      exception_select = 1;
      checks++;
      if (trap_busy !== 1'b1) begin errors++; $display("FAIL areset_pre got busy=%b want 1", trap_busy); end
      #2 resetn = 0;
      #1;
      checks++;
      if (trap_busy !== 1'b0 || trap_count !== 32'd0 || cause !== 32'd0) begin
         errors++; $display("FAIL areset_now got busy=%b cnt=%0d cause=%h want 0 0 0", trap_busy, trap_count, cause);
      end
      exc_valid = 0; exception_select = 0;
      @(posedge clk); #1;
      checks++;
      if (trap_ack !== 1'b0) begin errors++; $display("FAIL areset_ack got %b want 0", trap_ack); end
      @(negedge clk);
      resetn = 1;
      wait_event(5, seen);
      checks++;
      if (seen || trap_ack !== 1'b0) begin
         errors++; $display("FAIL areset_after got ev=%b ack=%b want 0 0", seen, trap_ack);
      end
   endtask

   initial begin
      test_reset();
      test_illegal();
      test_tval_pc();
      test_priority();
      test_masked();
      test_collision();
      test_wfi();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
